// File: rtl/lifo_arb_pkg.sv
// Shared types and defaults for the two-requester LIFO arbiter.
package lifo_arb_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int W_DEF     = 4;

    // LIFO operation encoding, identical to the LIFO's own RW input
    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, on a tie the
// requester that was not granted last wins.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // One-hot grant from current requests and last winner
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/lifo_arbiter.sv
// Serialises push/pop requests from two clients onto a single LIFO port.
// One transaction at a time: IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE.
// ack/err are registered, so they appear one cycle after RESP.
module lifo_arbiter
    import lifo_arb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int W     = W_DEF
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic [1:0]   req,
    input  logic [1:0]   rw,
    input  logic [W-1:0] din0,
    input  logic [W-1:0] din1,
    output logic [1:0]   ack,
    output logic [1:0]   err,
    output logic [W-1:0] dout,
    output logic         lifo_en,
    output logic         lifo_rw,
    output logic [W-1:0] lifo_din,
    input  logic [W-1:0] lifo_dout,
    input  logic         lifo_empty,
    input  logic         lifo_full
);

    localparam int             CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    state_t         state;
    state_t         state_nxt;
    logic [1:0]     grant;
    logic           g;
    logic           last_grant;
    logic           op_rw;
    logic [W-1:0]   op_din;
    logic           err_flag;
    logic           illegal;
    logic [CW-1:0]  count;

    rr_arbiter2 u_rr (
        .req        (req),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Reject pushes into a full stack and pops from an empty one; both the
    // local count and the LIFO's own flags are honoured.
    assign illegal = (op_rw == OP_POP) ? ((count == '0) || lifo_empty)
                                       : ((count == CNT_MAX) || lifo_full);

    // State register
    always_ff @(posedge Clk or negedge Rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!Rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        // NOTE: default assigned first so no branch can leave state_nxt
        // unassigned and infer a latch.
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = ISSUE;
            ISSUE:   state_nxt = illegal ? RESP : WAIT;
            WAIT:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // LIFO port drive: active only for a legal op in ISSUE
    always_comb begin
        lifo_en  = 1'b0;
        lifo_rw  = 1'b0;
        lifo_din = '0;
        if (state == ISSUE && !illegal) begin
            lifo_en  = 1'b1;
            lifo_rw  = op_rw;
            lifo_din = op_din;
        end
    end

    // Transaction latch, occupancy count, pop data and response pulses
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            g          <= 1'b0;
            last_grant <= 1'b1;
            op_rw      <= 1'b0;
            op_din     <= '0;
            err_flag   <= 1'b0;
            count      <= '0;
            dout       <= '0;
            ack        <= 2'b00;
            err        <= 2'b00;
        end else begin
            ack <= 2'b00;
            err <= 2'b00;
            case (state)
                IDLE: begin
                    if (|req) begin
                        g        <= grant[1];
                        op_rw    <= grant[0] ? rw[0] : rw[1];
                        op_din   <= grant[0] ? din0  : din1;
                        err_flag <= 1'b0;
                    end
                end
                ISSUE: begin
                    err_flag <= illegal;
                    if (!illegal) begin
                        if (op_rw == OP_POP) count <= count - 1'b1;
                        else                 count <= count + 1'b1;
                    end
                end
                WAIT: begin
                    if (op_rw == OP_POP) dout <= lifo_dout;
                end
                RESP: begin
                    ack        <= g ? 2'b10 : 2'b01;
                    err        <= err_flag ? (g ? 2'b10 : 2'b01) : 2'b00;
                    last_grant <= g;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lifo_arbiter.sv
// Self-checking bench for lifo_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_lifo_arbiter;

    localparam int DEPTH = 4;
    localparam int W     = 4;

    logic         Clk   = 1'b0;
    logic         Rst_n = 1'b0;
    logic [1:0]   req   = 2'b00;
    logic [1:0]   rw    = 2'b00;
    logic [W-1:0] din0  = '0;
    logic [W-1:0] din1  = '0;
    logic [1:0]   ack;
    logic [1:0]   err;
    logic [W-1:0] dout;
    logic         lifo_en;
    logic         lifo_rw;
    logic [W-1:0] lifo_din;
    logic [W-1:0] lifo_dout;
    logic         lifo_empty;
    logic         lifo_full;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    lifo_arbiter #(.DEPTH(DEPTH), .W(W)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .req        (req),
        .rw         (rw),
        .din0       (din0),
        .din1       (din1),
        .ack        (ack),
        .err        (err),
        .dout       (dout),
        .lifo_en    (lifo_en),
        .lifo_rw    (lifo_rw),
        .lifo_din   (lifo_din),
        .lifo_dout  (lifo_dout),
        .lifo_empty (lifo_empty),
        .lifo_full  (lifo_full)
    );

    // Attached LIFO: registered read data, reset with the system
    logic [W-1:0] mem [DEPTH];
    int sp;
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sp        <= 0;
            lifo_dout <= '0;
        end else if (lifo_en) begin
            if (!lifo_rw) begin
                if (sp < DEPTH) begin
                    mem[sp] <= lifo_din;
                    sp      <= sp + 1;
                end
            end else if (sp > 0) begin
                lifo_dout <= mem[sp-1];
                sp        <= sp - 1;
            end
        end
    end
    assign lifo_empty = (sp == 0);
    assign lifo_full  = (sp == DEPTH);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // e counts rising edges out of reset; a request seen at edge N produces
    // lifo_en after N (legal only) and ack after N+3 (legal) or N+2 (rejected).
    int           e         = 0;
    int           free_edge = 0;
    int           ack_edge  = -1;
    int           en_edge   = -1;
    logic         m_last    = 1'b1;
    int           m_g       = 0;
    logic         m_err     = 1'b0;
    logic         m_rw      = 1'b0;
    logic [W-1:0] m_din     = '0;
    logic [W-1:0] m_dout    = '0;
    logic [W-1:0] m_stack[$];

    initial forever begin
        @(posedge Clk or negedge Rst_n);
        if (!Rst_n) begin
            m_stack.delete();
            m_last    = 1'b1;
            free_edge = 0;
            ack_edge  = -1;
            en_edge   = -1;
        end else begin
            e++;
            if (e >= free_edge && req != 2'b00) begin
                if (req == 2'b11) m_g = m_last ? 0 : 1;
                else              m_g = req[1] ? 1 : 0;
                m_rw  = rw[m_g];
                m_din = (m_g == 1) ? din1 : din0;
                m_err = m_rw ? (m_stack.size() == 0) : (m_stack.size() == DEPTH);
                if (!m_err) begin
                    if (m_rw) m_dout = m_stack.pop_back();
                    else      m_stack.push_back(m_din);
                    en_edge   = e;
                    ack_edge  = e + 3;
                    free_edge = e + 4;
                end else begin
                    ack_edge  = e + 2;
                    free_edge = e + 3;
                end
                m_last = (m_g == 1);
            end
        end
    end

    // Compare process: every cycle out of reset, on the falling edge
    initial forever begin
        logic [1:0] exp_ack;
        logic [1:0] exp_err;
        @(negedge Clk);
        if (Rst_n) begin
            exp_ack = 2'b00;
            exp_err = 2'b00;
            if (e == ack_edge) begin
                exp_ack = (m_g == 1) ? 2'b10 : 2'b01;
                exp_err = m_err ? exp_ack : 2'b00;
            end
            check("model ack", ack, exp_ack);
            check("model err", err, exp_err);
            check("model lifo_en", lifo_en, e == en_edge);
            if (e == en_edge) begin
                check("model lifo_rw", lifo_rw, m_rw);
                check("model lifo_din", lifo_din, m_din);
            end
            if (e == ack_edge && !m_err && m_rw)
                check("model dout", dout, m_dout);
        end
    end

    // One request from requester idx; reports ack latency (edges after the
    // sampling edge), lifo_en cycles seen, err and dout at ack.
    task automatic do_op(input int idx, input logic op, input logic [W-1:0] d, input bit drop_early,
                         output int lat, output int ens, output logic eb, output logic [W-1:0] dv);
        lat = -1;
        ens = 0;
        eb  = 1'b0;
        dv  = '0;
        @(posedge Clk); #1;
        req[idx] = 1'b1;
        rw[idx]  = op;
        if (idx == 1) din1 = d; else din0 = d;
        for (int t = 1; t <= 12; t++) begin
            @(posedge Clk); #1;
            if (drop_early && t == 1) req[idx] = 1'b0;
            if (lifo_en) ens++;
            if (ack[idx]) begin
                lat = t - 1;
                eb  = err[idx];
                dv  = dout;
                req[idx] = 1'b0;
                break;
            end
        end
        req[idx] = 1'b0;
    endtask

    task automatic op_check(input string nm, input int idx, input logic op, input logic [W-1:0] d,
                            input bit drop_early, input logic exp_err, input logic [W-1:0] exp_dout);
        int lat;
        int ens;
        logic eb;
        logic [W-1:0] dv;
        do_op(idx, op, d, drop_early, lat, ens, eb, dv);
        check({nm, " latency"}, lat, exp_err ? 2 : 3);
        check({nm, " err"}, eb, exp_err);
        check({nm, " lifo_en cycles"}, ens, exp_err ? 0 : 1);
        if (op && !exp_err) check({nm, " dout"}, dv, exp_dout);
    endtask

    task automatic do_reset();
        @(posedge Clk); #1;
        req   = 2'b00;
        Rst_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1 Rst_n = 1'b1;
    endtask

    initial begin
        int           k;
        logic [1:0]   grants[4];
        int           wait_cnt[2];

        // Reset state
        repeat (3) @(posedge Clk);
        #1;
        check("reset ack", ack, 2'b00);
        check("reset err", err, 2'b00);
        check("reset dout", dout, 0);
        check("reset lifo_en", lifo_en, 0);
        check("reset lifo_rw", lifo_rw, 0);
        check("reset lifo_din", lifo_din, 0);
        Rst_n = 1'b1;

        // Underflow straight after reset
        op_check("underflow", 0, 1'b1, 4'h0, 1'b0, 1'b1, 4'h0);

        // Push then pop
        op_check("push A", 0, 1'b0, 4'hA, 1'b0, 1'b0, 4'h0);
        op_check("pop A", 0, 1'b1, 4'h0, 1'b0, 1'b0, 4'hA);

        // Fill, overflow, drain in reverse order
        for (int i = 1; i <= 4; i++) op_check("fill push", 1, 1'b0, 4'(i), 1'b0, 1'b0, 4'h0);
        op_check("overflow push", 1, 1'b0, 4'h5, 1'b0, 1'b1, 4'h0);
        for (int i = 4; i >= 1; i--) op_check("drain pop", 1, 1'b1, 4'h0, 1'b0, 1'b0, 4'(i));
        op_check("pop empty", 1, 1'b1, 4'h0, 1'b0, 1'b1, 4'h0);

        // Reset during WAIT of a legal push
        @(posedge Clk); #1;
        req[0] = 1'b1; rw[0] = 1'b0; din0 = 4'h7;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        req[0] = 1'b0;
        Rst_n  = 1'b0;
        #1;
        check("midop ack", ack, 2'b00);
        check("midop err", err, 2'b00);
        check("midop dout", dout, 0);
        check("midop lifo_en", lifo_en, 0);
        check("midop lifo_rw", lifo_rw, 0);
        check("midop lifo_din", lifo_din, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk); #1;
            check("midop no ack", ack, 2'b00);
        end
        Rst_n = 1'b1;
        op_check("pop after reset", 0, 1'b1, 4'h0, 1'b0, 1'b1, 4'h0);

        // Contention from a fresh reset: grants alternate starting with 0
        do_reset();
        @(posedge Clk); #1;
        rw   = 2'b00;
        din0 = 4'h5;
        din1 = 4'h6;
        req  = 2'b11;
        k = 0;
        for (int c = 0; c < 40 && k < 4; c++) begin
            @(posedge Clk); #1;
            if (ack != 2'b00) begin
                grants[k] = ack;
                k++;
            end
        end
        req = 2'b00;
        check("contention acks seen", k, 4);
        check("contention grant 0", grants[0], 2'b01);
        check("contention grant 1", grants[1], 2'b10);
        check("contention grant 2", grants[2], 2'b01);
        check("contention grant 3", grants[3], 2'b10);

        // Request dropped right after sampling still completes
        op_check("early drop pop", 0, 1'b1, 4'h0, 1'b1, 1'b0, 4'h6);

        // Randomized traffic with fairness tracking
        wait_cnt[0] = 0;
        wait_cnt[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge Clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (req[i] && ack[1-i]) wait_cnt[i]++;
                if (req[i] && ack[i]) begin
                    check("fairness over limit", wait_cnt[i] > 1, 0);
                    req[i]      = 1'b0;
                    wait_cnt[i] = 0;
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    rw[i]  = 1'($urandom_range(0, 1));
                    if (i == 1) din1 = W'($urandom);
                    else        din0 = W'($urandom);
                    req[i] = 1'b1;
                    wait_cnt[i] = 0;
                end
            end
        end
        req = 2'b00;
        repeat (6) @(posedge Clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard bound on total runtime
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
